// File: rtl/iob_ibex_clint.sv
// iob_ibex_clint: RISC-V CLINT (msip, mtime, mtimecmp) on an IOb native bus for an Ibex core
// Ports: clk_i/arst_ni (async active-low)/cke_i clock enable; clint_iob_* IOb slave
// (valid/addr/wdata/wstrb in, ready/rvalid/rdata out); irq_software_o, irq_timer_o to the core.
// Build option: define IOB_IBEX_CLINT_PRESCALER_EN to tick mtime once every TICK_DIV cycles;
// otherwise mtime ticks on every enabled cycle and TICK_DIV is unused.
module iob_ibex_clint #(
  parameter int unsigned TICK_DIV = 16
) (
  input  logic        clk_i,
  input  logic        arst_ni,
  input  logic        cke_i,
  input  logic        clint_iob_valid_i,
  input  logic [13:0] clint_iob_addr_i,
  input  logic [31:0] clint_iob_wdata_i,
  input  logic [3:0]  clint_iob_wstrb_i,
  output logic        clint_iob_rvalid_o,
  output logic [31:0] clint_iob_rdata_o,
  output logic        clint_iob_ready_o,
  output logic        irq_software_o,
  output logic        irq_timer_o
);
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d, irq_timer_q, rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d, rval;
  logic [11:0] wa;
  logic        acc, wr, rd, tick, wr_time;
  logic        s_msip, s_cmp_lo, s_cmp_hi, s_time_lo, s_time_hi;
  logic        unused_addr;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
    for (int i = 0; i < 4; i++) merge[i*8 +: 8] = strb[i] ? nw[i*8 +: 8] : old[i*8 +: 8];
  endfunction

  assign unused_addr       = ^clint_iob_addr_i[1:0];
  assign clint_iob_ready_o = cke_i;
  assign acc       = clint_iob_valid_i & cke_i;
  assign wr        = acc & |clint_iob_wstrb_i;
  assign rd        = acc & ~|clint_iob_wstrb_i;
  assign wa        = clint_iob_addr_i[13:2];
  assign s_msip    = wa == 12'h000;
  assign s_cmp_lo  = wa == 12'h800;
  assign s_cmp_hi  = wa == 12'h801;
  assign s_time_lo = wa == 12'hFFE;
  assign s_time_hi = wa == 12'hFFF;
  assign wr_time   = wr & (s_time_lo | s_time_hi);

`ifdef IOB_IBEX_CLINT_PRESCALER_EN
  logic [15:0] ps_q, ps_d;
  assign tick = ps_q == 16'(TICK_DIV - 1);
  // A bus write to mtime restarts the tick period from zero.
  assign ps_d = (wr_time | tick) ? 16'd0 : ps_q + 16'd1;
  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) ps_q <= '0;
    else if (cke_i) ps_q <= ps_d;
`else
  localparam int unsigned unused_tick_div = TICK_DIV;
  assign tick = 1'b1;
`endif

  always_comb begin
    // A bus write to either half of mtime wins over a same-cycle tick.
    mtime_d    = (wr & s_time_lo) ? {mtime_q[63:32], merge(mtime_q[31:0], clint_iob_wdata_i, clint_iob_wstrb_i)} :
                 (wr & s_time_hi) ? {merge(mtime_q[63:32], clint_iob_wdata_i, clint_iob_wstrb_i), mtime_q[31:0]} :
                 tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = (wr & s_cmp_lo) ? {mtimecmp_q[63:32], merge(mtimecmp_q[31:0], clint_iob_wdata_i, clint_iob_wstrb_i)} :
                 (wr & s_cmp_hi) ? {merge(mtimecmp_q[63:32], clint_iob_wdata_i, clint_iob_wstrb_i), mtimecmp_q[31:0]} :
                 mtimecmp_q;
    msip_d     = (wr & s_msip & clint_iob_wstrb_i[0]) ? clint_iob_wdata_i[0] : msip_q;
    rval       = s_msip ? {31'd0, msip_q} : s_cmp_lo ? mtimecmp_q[31:0] : s_cmp_hi ? mtimecmp_q[63:32] :
                 s_time_lo ? mtime_q[31:0] : s_time_hi ? mtime_q[63:32] : 32'd0;
    rvalid_d   = rd;
    rdata_d    = rd ? rval : rdata_q;
  end

  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      irq_timer_q <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else if (cke_i) begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      irq_timer_q <= mtime_q >= mtimecmp_q;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end

  assign clint_iob_rvalid_o = rvalid_q;
  assign clint_iob_rdata_o  = rdata_q;
  assign irq_software_o     = msip_q;
  assign irq_timer_o        = irq_timer_q;
endmodule

// File: tb/tb_iob_ibex_clint.sv
// tb_iob_ibex_clint: directed scoreboard bench for iob_ibex_clint
module tb_iob_ibex_clint;
  logic        clk_i = 1'b0, arst_ni = 1'b0, cke_i = 1'b1, valid = 1'b0;
  logic [13:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        rvalid, ready, irq_sw, irq_t;
  logic [31:0] rdata;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [13:0] a; logic [31:0] e;} exp_t;
  exp_t sbq[$];

  always #5 clk_i = ~clk_i;

  iob_ibex_clint #(.TICK_DIV(4)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .cke_i(cke_i),
    .clint_iob_valid_i(valid), .clint_iob_addr_i(addr), .clint_iob_wdata_i(wdata),
    .clint_iob_wstrb_i(wstrb), .clint_iob_rvalid_o(rvalid), .clint_iob_rdata_o(rdata),
    .clint_iob_ready_o(ready), .irq_software_o(irq_sw), .irq_timer_o(irq_t)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s);
    addr = a; wdata = d; wstrb = s; valid = 1'b1;
    @(negedge clk_i);
    valid = 1'b0; wstrb = '0;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    xfer(a, d, s);
  endtask

  task automatic rd(input logic [13:0] a, input logic [31:0] e);
    sbq.push_back('{a, e});
    xfer(a, 32'd0, 4'd0);
  endtask

  always @(negedge clk_i)
    if (rvalid) begin
      if (sbq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_rvalid: got rdata %h expected no response", rdata);
      end else begin
        exp_t x;
        x = sbq.pop_front();
        chk($sformatf("read_%h", x.a), rdata, x.e);
      end
    end

  initial begin
    #3;
    chk("rst_irq_timer", 32'(irq_t), 0);
    chk("rst_irq_sw", 32'(irq_sw), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk_i);
    arst_ni = 1'b1;
    rd(14'h2000, 32'hFFFF_FFFF);
    rd(14'h2004, 32'hFFFF_FFFF);
    rd(14'h0000, 32'd0);
    chk("post_rst_irq_timer", 32'(irq_t), 0);
    chk("post_rst_irq_sw", 32'(irq_sw), 0);
    chk("ready_cke1", 32'(ready), 1);
    // msip byte lanes and software interrupt
    wr(14'h0000, 32'd1, 4'b0010);
    chk("msip_wrong_lane", 32'(irq_sw), 0);
    wr(14'h0000, 32'd1, 4'b0001);
    chk("msip_set", 32'(irq_sw), 1);
    wr(14'h0000, 32'hFFFF_FFFF, 4'b0001);
    rd(14'h0000, 32'd1);
    wr(14'h0000, 32'hFFFF_FFFE, 4'b0001);
    chk("msip_clr", 32'(irq_sw), 0);
    // mtimecmp lanes, unmapped space, ignored addr[1:0], rdata hold
    wr(14'h2000, 32'h1122_3344);
    wr(14'h2000, 32'hAABB_CCDD, 4'b0101);
    rd(14'h2000, 32'h11BB_33DD);
    wr(14'h1000, 32'hDEAD_BEEF);
    rd(14'h1000, 32'd0);
    rd(14'h2003, 32'h11BB_33DD);
    repeat (3) @(negedge clk_i);
    chk("rdata_hold", rdata, 32'h11BB_33DD);
    wr(14'h2000, 32'hFFFF_FFFF);
`ifndef IOB_IBEX_CLINT_PRESCALER_EN
    // timer interrupt: mtime = n at the n-th negedge after the mtime_lo write
    wr(14'h3FFC, 32'd0);
    wr(14'h3FF8, 32'd0);
    wr(14'h2004, 32'd0);
    wr(14'h2000, 32'd100);
    rd(14'h3FF8, 32'd2);
    repeat (97) @(negedge clk_i);
    chk("irq_timer_before", 32'(irq_t), 0);
    @(negedge clk_i);
    chk("irq_timer_rise", 32'(irq_t), 1);
    wr(14'h2000, 32'hFFFF_FFFF);
    chk("irq_timer_hold", 32'(irq_t), 1);
    @(negedge clk_i);
    chk("irq_timer_fall", 32'(irq_t), 0);
    // 64-bit wrap-around
    wr(14'h3FFC, 32'hFFFF_FFFF);
    wr(14'h3FF8, 32'hFFFF_FFFE);
    repeat (2) @(negedge clk_i);
    rd(14'h3FF8, 32'd0);
    rd(14'h3FFC, 32'd0);
    // write beats tick; mtime then advances every cycle
    wr(14'h3FF8, 32'd7);
    rd(14'h3FF8, 32'd7);
    rd(14'h3FF8, 32'd8);
`else
    // prescaler: align a write with a tick, then one increment per 4 cycles
    wr(14'h3FFC, 32'd0);
    wr(14'h3FF8, 32'd7);
    repeat (3) @(negedge clk_i);
    wr(14'h3FF8, 32'd7);
    rd(14'h3FF8, 32'd7);
    repeat (2) @(negedge clk_i);
    rd(14'h3FF8, 32'd7);
    rd(14'h3FF8, 32'd8);
    repeat (3) @(negedge clk_i);
    rd(14'h3FF8, 32'd9);
`endif
    // clock enable freezes everything and drops ready
    wr(14'h3FF8, 32'h1000);
    cke_i = 1'b0;
    xfer(14'h3FF8, 32'h5555, 4'hF);
    repeat (4) begin
      chk("ready_cke0", 32'(ready), 0);
      @(negedge clk_i);
    end
    cke_i = 1'b1;
    rd(14'h3FF8, 32'h1000);
    // reset in the cycle after an accepted read
    wr(14'h0000, 32'd1, 4'b0001);
    addr = 14'h2000; wstrb = '0; valid = 1'b1;
    @(posedge clk_i);
    #1 valid = 1'b0;
    chk("rvalid_before_rst", 32'(rvalid), 1);
    arst_ni = 1'b0;
    #1;
    chk("midrst_rvalid", 32'(rvalid), 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_irq_sw", 32'(irq_sw), 0);
    chk("midrst_irq_timer", 32'(irq_t), 0);
    @(negedge clk_i);
    arst_ni = 1'b1;
    rd(14'h2000, 32'hFFFF_FFFF);
    rd(14'h2004, 32'hFFFF_FFFF);
    rd(14'h0000, 32'd0);
    rd(14'h3FFC, 32'd0);
    repeat (3) @(negedge clk_i);
    chk("scoreboard_drained", 32'(sbq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
